// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving the datapath selects plus a
// saturating retired-instruction counter.
module mips_mc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Function,
  input  logic             Zero,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             PCSel,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUCtrl,
  output logic             halt,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0110;
  localparam logic [3:0] ALU_SUB = 4'b1110;
  localparam logic [3:0] ALU_SLT = 4'b1111;

  logic [3:0]       state_reg;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] count_reg;
  logic             funct_valid;
  logic [3:0]       funct_alu;
  logic             retire;

  // R-type funct decode; unlisted codes fall back to ADD and are flagged invalid.
  always_comb begin
    funct_valid = 1'b1;
    funct_alu   = ALU_ADD;
    case (Function)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h26:   funct_alu = ALU_XOR;
      6'h27:   funct_alu = ALU_NOR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    state_next = S_HALT;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_HALT;
        endcase
      end
      S_MEMADR: state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = S_FETCH;
      S_EXEC:   state_next = funct_valid ? S_ALUWB : S_HALT;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_ADDIEX: state_next = S_ADDIWB;
      S_ADDIWB: state_next = S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  // Every state that returns to FETCH is the last cycle of an instruction.
  always_comb begin
    retire = 1'b0;
    case (state_reg)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire && (count_reg != {CNT_W{1'b1}}))
        count_reg <= count_reg + 1'b1;
    end
  end

  always_comb begin
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    IRWrite  = 1'b0;
    ALUSrcA  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    PCSel    = 1'b0;
    PCSource = 2'b00;
    ALUSrcB  = 2'b00;
    ALUCtrl  = ALU_ADD;
    halt     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCSel   = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = funct_alu;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtrl  = ALU_SUB;
        PCSource = 2'b01;
        PCSel    = Zero;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCSel    = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_HALT:   halt = 1'b1;
      default: ;
    endcase
    // Architectural side effects are suppressed while reset is held.
    if (reset) begin
      PCSel    = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      halt     = 1'b0;
    end
  end

  assign state       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: stimulus queues the expected per-cycle
// state/controls/count, a negedge monitor pops and compares.
module tb_mips_mc_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Op;
  logic [5:0]       Function;
  logic             Zero;
  logic             IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA;
  logic             RegWrite, RegDst, PCSel, halt;
  logic [1:0]       PCSource, ALUSrcB;
  logic [3:0]       ALUCtrl, state;
  logic [CNT_W-1:0] instr_count;

  mips_mc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Function(Function), .Zero(Zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst),
    .PCSel(PCSel), .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .halt(halt), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [3:0]       st;
    logic [17:0]      cw;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // {IorD,MemRead,MemWrite,MemToReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSel,PCSource,ALUSrcB,ALUCtrl,halt}
  function automatic logic [17:0] cw(input logic iord, mr, mw, m2r, irw, asa, rw, rd, pcs,
                                     input logic [1:0] pcsrc, asb,
                                     input logic [3:0] alu, input logic h);
    return {iord, mr, mw, m2r, irw, asa, rw, rd, pcs, pcsrc, asb, alu, h};
  endfunction

  // Reset clears halt(0), PCSel(9), RegWrite(11), IRWrite(13), MemWrite(15).
  function automatic logic [17:0] rst_mask(input logic [17:0] c);
    return c & ~18'h0AA01;
  endfunction

  logic [17:0] c_fetch, c_decode, c_memadr, c_memrd, c_memwb, c_memwr;
  logic [17:0] c_aluwb, c_jump, c_addiex, c_addiwb, c_halt;

  wire [17:0] dut_cw = {IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite,
                        RegDst, PCSel, PCSource, ALUSrcB, ALUCtrl, halt};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 3;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state step %0d: got %0d want %0d", e.id, state, e.st);
      end
      if (dut_cw !== e.cw) begin
        errors++;
        $display("FAIL controls step %0d state %0d: got %05h want %05h", e.id, e.st, dut_cw, e.cw);
      end
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL instr_count step %0d: got %0d want %0d", e.id, instr_count, e.cnt);
      end
    end
  end

  task automatic step(input logic [3:0] st, input logic [17:0] c, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.id = step_id; e.st = st; e.cw = c; e.cnt = cnt;
    exp_q.push_back(e);
    step_id++;
    $display("step %0d: reset=%0b Op=%02h Function=%02h Zero=%0b expect state=%0d ctl=%05h cnt=%0d",
             e.id, reset, Op, Function, Zero, st, c, cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic run_lw(input logic [CNT_W-1:0] cnt);
    Op = 6'h23;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    step(4'd2, c_memadr, cnt);
    Op = 6'h2B;  // ignored outside the decode-sampling states
    step(4'd3, c_memrd, cnt);
    step(4'd4, c_memwb, cnt);
  endtask

  task automatic run_sw(input logic [CNT_W-1:0] cnt);
    Op = 6'h2B;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    step(4'd2, c_memadr, cnt);
    Op = 6'h23;
    step(4'd5, c_memwr, cnt);
  endtask

  task automatic run_r(input logic [5:0] f, input logic [3:0] alu, input logic [CNT_W-1:0] cnt);
    Op = 6'h00; Function = f;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    step(4'd6, cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,alu,0), cnt);
    Function = 6'h3F;
    step(4'd7, c_aluwb, cnt);
  endtask

  task automatic run_addi(input logic [CNT_W-1:0] cnt);
    Op = 6'h08;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    step(4'd10, c_addiex, cnt);
    step(4'd11, c_addiwb, cnt);
  endtask

  task automatic run_beq(input logic z, input logic [CNT_W-1:0] cnt);
    Op = 6'h04; Zero = ~z;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    Zero = z;
    step(4'd8, cw(0,0,0,0,0,1,0,0,z,2'b01,2'b00,4'b1110,0), cnt);
  endtask

  task automatic run_j(input logic [CNT_W-1:0] cnt);
    Op = 6'h02;
    step(4'd0, c_fetch, cnt);
    step(4'd1, c_decode, cnt);
    step(4'd9, c_jump, cnt);
  endtask

  logic [5:0] r_funct [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A};
  logic [3:0] r_alu   [7] = '{4'b0110, 4'b1110, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111};

  initial begin
    c_fetch  = cw(0,1,0,0,1,0,0,0,1,2'b00,2'b01,4'b0110,0);
    c_decode = cw(0,0,0,0,0,0,0,0,0,2'b00,2'b11,4'b0110,0);
    c_memadr = cw(0,0,0,0,0,1,0,0,0,2'b00,2'b10,4'b0110,0);
    c_memrd  = cw(1,1,0,0,0,0,0,0,0,2'b00,2'b00,4'b0110,0);
    c_memwb  = cw(0,0,0,1,0,0,1,0,0,2'b00,2'b00,4'b0110,0);
    c_memwr  = cw(1,0,1,0,0,0,0,0,0,2'b00,2'b00,4'b0110,0);
    c_aluwb  = cw(0,0,0,0,0,0,1,1,0,2'b00,2'b00,4'b0110,0);
    c_jump   = cw(0,0,0,0,0,0,0,0,1,2'b10,2'b00,4'b0110,0);
    c_addiex = cw(0,0,0,0,0,1,0,0,0,2'b00,2'b10,4'b0110,0);
    c_addiwb = cw(0,0,0,0,0,0,1,0,0,2'b00,2'b00,4'b0110,0);
    c_halt   = cw(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'b0110,1);

    reset = 1'b1; Op = 6'h00; Function = 6'h00; Zero = 1'b0;
    @(posedge clk); #1;
    step(4'd0, rst_mask(c_fetch), 4'd0);
    reset = 1'b0;

    run_lw(4'd0);
    run_sw(4'd1);
    for (int i = 0; i < 7; i++) run_r(r_funct[i], r_alu[i], 4'(2 + i));
    run_addi(4'd9);
    run_beq(1'b1, 4'd10);
    run_beq(1'b0, 4'd11);
    run_j(4'd12);
    run_j(4'd13);
    run_j(4'd14);
    run_j(4'd15);  // counter saturated at all-ones
    run_j(4'd15);

    // Unlisted funct traps to HALT without retiring.
    Op = 6'h00; Function = 6'h3F;
    step(4'd0, c_fetch, 4'd15);
    step(4'd1, c_decode, 4'd15);
    step(4'd6, cw(0,0,0,0,0,1,0,0,0,2'b00,2'b00,4'b0110,0), 4'd15);
    Op = 6'h02;
    step(4'd12, c_halt, 4'd15);
    Op = 6'h23;
    step(4'd12, c_halt, 4'd15);
    reset = 1'b1;
    step(4'd12, rst_mask(c_halt), 4'd15);
    reset = 1'b0;

    // Unknown opcode traps from DECODE.
    Op = 6'h3F;
    step(4'd0, c_fetch, 4'd0);
    step(4'd1, c_decode, 4'd0);
    step(4'd12, c_halt, 4'd0);
    reset = 1'b1;
    step(4'd12, rst_mask(c_halt), 4'd0);
    reset = 1'b0;

    // Reset in the middle of a load aborts it and clears the count.
    run_j(4'd0);
    Op = 6'h23;
    step(4'd0, c_fetch, 4'd1);
    step(4'd1, c_decode, 4'd1);
    step(4'd2, c_memadr, 4'd1);
    reset = 1'b1;
    step(4'd3, rst_mask(c_memrd), 4'd1);
    step(4'd0, rst_mask(c_fetch), 4'd0);
    reset = 1'b0;
    run_j(4'd0);
    step(4'd0, c_fetch, 4'd1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 Parameter CNT_W, 16: width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Op  input  6  opcode field of the current instruction register.
REQ-005 Function  input  6  funct field; qualified only when Op==0.
REQ-006 Zero  input  1  ALU-result-is-zero flag from the datapath.
REQ-007 IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSel  output  1 each  datapath controls.
REQ-008 PCSource  output  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 ALUSrcB  output  2  operand-B select: 00 RB, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
REQ-010 ALUCtrl  output  4  ALU op: 0000 AND, 0001 OR, 0010 XOR, 0011 NOR, 0110 ADD, 1110 SUB, 1111 SLT.
REQ-011 halt  output  1  high while in HALT state.
REQ-012 state  output  4  current state encoding.
REQ-013 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-014 Moore FSM. Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 12; codes 13-15 go to HALT.
REQ-015 Outputs not listed for a state are 0, except ALUCtrl, which defaults to 0110.
REQ-016 FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSource=00, PCSel=1; next state DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut).
REQ-017a DECODE next state by Op: 0x23/0x2B -> MEMADR; 0x00 -> EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDIEX; any other Op -> HALT.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ADD; next state MEMRD if Op==0x23, else MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1; next state MEMWB.
REQ-019a MEMWB: RegWrite=1, MemToReg=1, RegDst=0; next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; next state FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00; ALUCtrl from Function: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT.
REQ-021a EXEC next state: ALUWB for a listed Function; HALT for any other Function.
REQ-022 ALUWB: RegWrite=1, RegDst=1, MemToReg=0; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01, PCSel=Zero (same-cycle combinational); next state FETCH.
REQ-024 JUMP: PCSource=10, PCSel=1; next state FETCH.
REQ-025 ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD; next state ADDIWB.
REQ-025a ADDIWB: RegWrite=1, RegDst=0, MemToReg=0; next state FETCH.
REQ-026 HALT: all enables 0, halt=1; remains in HALT until reset.
REQ-027 Cycles per instruction, FETCH inclusive: lw 5; sw, R-type, addi 4; beq, j 3.
REQ-028 instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB.
REQ-028a instr_count saturates at 2^CNT_W-1 and never wraps.
REQ-028b Entry into HALT does not increment instr_count.
REQ-029 Op and Function are sampled only in DECODE, MEMADR and EXEC; changes in other states have no effect.

Reset
REQ-030 While reset=1, state is forced to FETCH on each clock edge and instr_count to 0.
REQ-030a While reset=1, PCSel, IRWrite, RegWrite and MemWrite are forced to 0 combinationally; halt=0.
REQ-031 Reset asserted in any state, including HALT or mid-instruction, aborts the instruction with no increment; the first non-reset cycle is FETCH with full FETCH outputs.

Verification
REQ-032 Reset, then Op=0x23 -> states 0,1,2,3,4,0; MemWrite never 1; RegWrite=1 with MemToReg=1 only in state 4; instr_count=1.
REQ-033 Op=0x00, Function=0x22 -> EXEC drives ALUCtrl=1110, ALUSrcB=00; ALUWB drives RegDst=1; 4 cycles.
REQ-033a Op=0x00, Function=0x3F -> state 12, halt=1; instr_count unchanged.
REQ-034 Op=0x04 with Zero=1 in BRANCH -> PCSel=1, PCSource=01; rerun with Zero=0 -> PCSel=0; both return to FETCH after 3 cycles.
REQ-035 Op=0x2B -> states 0,1,2,5,0; MemWrite=1, IorD=1 in state 5 only; RegWrite never 1.
REQ-036 Reset mid-MEMRD -> next cycle state=0, instr_count=0, IRWrite=0 during reset.
REQ-036a Force instr_count to 0xFFFF and complete j -> instr_count stays 0xFFFF.
